mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port SRAM between the data stage, the fetch stage
// and a program loader; read data returns one cycle after its grant.
module mem_port_arbiter #(
    parameter int AW           = 10,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_mode,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          d_gnt,
    output logic          f_gnt,
    output logic          l_gnt,
    output logic          d_rvalid,
    output logic          f_rvalid,
    output logic          l_rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          in_load
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_D, OWN_F, OWN_L} owner_t;

    state_t        state, state_nxt;
    owner_t        owner, owner_nxt;
    logic [CW-1:0] starve;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          starved;
    logic          gnt;

    assign starved = (starve == CW'(STARVE_LIMIT));

    always_comb begin
        d_gnt     = 1'b0;
        f_gnt     = 1'b0;
        l_gnt     = 1'b0;
        state_nxt = state;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (f_req && (starved || !d_req)) f_gnt = 1'b1;
                    else if (d_req)                   d_gnt = 1'b1;
                    if (load_mode) state_nxt = DRAIN;
                end
                // DRAIN issues nothing, so a read in flight returns during
                // this cycle and nothing is outstanding beyond it.
                DRAIN: state_nxt = load_mode ? LOAD : RUN;
                LOAD: begin
                    l_gnt = l_req;
                    if (!load_mode) state_nxt = RUN;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    assign gnt    = d_gnt | f_gnt | l_gnt;
    assign mem_en = gnt;
    assign mem_we = (d_gnt & d_we) | (l_gnt & l_we);

    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        owner_nxt = OWN_NONE;
        if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            if (!d_we) owner_nxt = OWN_D;
        end else if (f_gnt) begin
            mem_addr  = f_addr;
            owner_nxt = OWN_F;
        end else if (l_gnt) begin
            mem_addr  = l_addr;
            mem_wdata = l_wdata;
            if (!l_we) owner_nxt = OWN_L;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            owner   <= OWN_NONE;
            starve  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            if (gnt) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
            end
            if (f_gnt || !f_req) starve <= '0;
            else if (d_gnt)      starve <= starve + CW'(1);
        end
    end

    assign d_rvalid = (owner == OWN_D);
    assign f_rvalid = (owner == OWN_F);
    assign l_rvalid = (owner == OWN_L);
    assign rdata    = (owner != OWN_NONE) ? mem_rdata : '0;
    assign in_load  = (state == LOAD);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: a behavioural arbiter and
// memory model predict grants per cycle and queue expected read returns.
module tb_mem_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_mode = 1'b0;
    logic          d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          f_req = 1'b0;
    logic [AW-1:0] f_addr = '0;
    logic          l_req = 1'b0, l_we = 1'b0;
    logic [AW-1:0] l_addr = '0;
    logic [DW-1:0] l_wdata = '0;
    logic          d_gnt, f_gnt, l_gnt, d_rvalid, f_rvalid, l_rvalid;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic          mem_en, mem_we, in_load;
    logic [AW-1:0] mem_addr;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst), .load_mode(load_mode),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .f_req(f_req), .f_addr(f_addr),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .d_gnt(d_gnt), .f_gnt(f_gnt), .l_gnt(l_gnt),
        .d_rvalid(d_rvalid), .f_rvalid(f_rvalid), .l_rvalid(l_rvalid),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .in_load(in_load)
    );

    always #5 clk = ~clk;

    // SRAM seen by the DUT
    logic [DW-1:0] sram [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] sram_q = '0;
    assign mem_rdata = sram_q;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        sram_q <= sram[mem_addr];
        end
    end

    typedef struct {
        int            owner;
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // model state: mode 0=RUN 1=DRAIN 2=LOAD
    int            m_mode = 0;
    int            m_starve = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int who;
        int got;
        logic          e_en, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        exp_t          e;
        cyc++;
        if (rst) begin
            chk("reset_outputs",
                {d_gnt, f_gnt, l_gnt, d_rvalid, f_rvalid, l_rvalid, mem_en, mem_we, in_load},
                64'd0);
            chk("reset_buses", {rdata, mem_addr, mem_wdata} == '0, 64'd1);
            m_mode = 0; m_starve = 0; m_addr = '0; m_wdata = '0;
            exp_q.delete();
        end else begin
            who = 0;  // 1=D 2=F 3=L
            if (m_mode == 0) begin
                if (f_req && (m_starve == SL || !d_req)) who = 2;
                else if (d_req)                          who = 1;
            end else if (m_mode == 2 && l_req) who = 3;
            chk("grants", {d_gnt, f_gnt, l_gnt}, {61'd0, who == 1, who == 2, who == 3});

            e_en = (who != 0);
            e_we = (who == 1 && d_we) || (who == 3 && l_we);
            e_addr = who == 1 ? d_addr : who == 2 ? f_addr : who == 3 ? l_addr : m_addr;
            e_wdata = who == 1 ? d_wdata : who == 3 ? l_wdata : m_wdata;
            chk("mem_ctl", {mem_en, mem_we}, {62'd0, e_en, e_we});
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wdata);
            chk("in_load", in_load, m_mode == 2);

            chk("rvalid_onehot", $countones({d_rvalid, f_rvalid, l_rvalid}) <= 1, 64'd1);
            got = d_rvalid ? 1 : f_rvalid ? 2 : l_rvalid ? 3 : 0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                chk("rvalid_owner", got, e.owner);
                chk("rdata", rdata, e.data);
            end else begin
                chk("no_rvalid", got, 0);
            end

            if (e_en) begin
                if (e_we) ref_mem[e_addr] = e_wdata;
                else exp_q.push_back('{owner: who, data: ref_mem[e_addr], due: cyc + 1});
                m_addr = e_addr;
                m_wdata = e_wdata;
            end
            if (who == 2 || !f_req) m_starve = 0;
            else if (who == 1)      m_starve++;
            case (m_mode)
                0: if (load_mode) m_mode = 1;
                1: m_mode = load_mode ? 2 : 0;
                default: if (!load_mode) m_mode = 0;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ports();
        d_addr = AW'($urandom); d_wdata = $urandom;
        f_addr = AW'($urandom);
        l_addr = AW'($urandom); l_wdata = $urandom;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            sram[i] = $urandom;
            ref_mem[i] = sram[i];
        end
        // grants must stay low while reset is held
        d_req = 1'b1; f_req = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // continuous d+f contention: D,D,D,D,F pattern
        d_we = 1'b0;
        repeat (40) begin rand_ports(); step(); end

        // write then fetch a known word
        f_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 10'h005; d_wdata = 32'hDEADBEEF;
        step();
        d_req = 1'b0; d_we = 1'b0; f_req = 1'b1; f_addr = 10'h005;
        step();
        f_req = 1'b0;

        // idle stretch
        repeat (10) step();

        // load entry with a read in flight, loader writes, then exit
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h00A; load_mode = 1'b1;
        l_req = 1'b1; l_we = 1'b1; l_addr = 10'h3FF; l_wdata = 32'h12345678;
        repeat (5) step();
        l_we = 1'b0;
        repeat (2) step();
        load_mode = 1'b0;
        repeat (3) step();
        d_req = 1'b0; l_req = 1'b0;

        // reset during the return cycle of a fetch
        f_req = 1'b1; f_addr = 10'h3FF;
        step();
        f_req = 1'b0;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        d_req = 1'b1; d_addr = 10'h3FF;
        step();
        d_req = 1'b0;

        // randomized traffic with occasional loader sessions
        repeat (400) begin
            rand_ports();
            d_req = ($urandom_range(0, 3) != 0);
            f_req = ($urandom_range(0, 2) != 0);
            d_we  = ($urandom_range(0, 2) == 0);
            l_req = $urandom_range(0, 1);
            l_we  = $urandom_range(0, 1);
            if ($urandom_range(0, 15) == 0) load_mode = ~load_mode;
            step();
        end
        d_req = 1'b0; f_req = 1'b0; l_req = 1'b0; load_mode = 1'b0;
        repeat (4) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_reads actual %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
